rmt_stage_link: RTL and testbench

- Parametrised elastic link between two RMT pipeline stages: PHV FIFO of configurable depth, with a slack-aware registered ready.
- Also a registered pass-through of the control AXI-Stream (table/config writes) with the same one-cycle alignment as the stage datapath.
- Successor to the fixed direct stage-to-stage wiring: lets a stage absorb downstream back-pressure without stalling the parser, and reports overflow.
- Instantiated between stage N's phv_out and stage N+1's phv_in.

---
 rtl/rmt_stage_link.sv | 128 ++++++++++++
 tb/tb_rmt_stage_link.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rmt_stage_link.sv
// Elastic PHV FIFO between RMT stages, plus a control stream that is registered once. Defining STAGE_LINK_STATS_EN adds a high-water register.
// A PHV pushed into an empty FIFO appears one cycle later. ready_out is registered and falls while READY_SLACK entries are still free. A push into a full FIFO with no pop is dropped and counted.
module rmt_stage_link #(
  parameter int PHV_LEN              = 1124,
  parameter int DEPTH                = 4,
  parameter int READY_SLACK          = 2,
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int STAGE_ID             = 0
) (
  input  logic                              axis_clk,
  input  logic                              aresetn,
  input  logic [PHV_LEN-1:0]                phv_in,
  input  logic                              phv_in_valid,
  output logic                              ready_out,
  output logic [PHV_LEN-1:0]                phv_out,
  output logic                              phv_out_valid,
  input  logic                              ready_in,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
  input  logic                              c_s_axis_tvalid,
  input  logic                              c_s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
  output logic                              c_m_axis_tvalid,
  output logic                              c_m_axis_tlast,
  output logic [$clog2(DEPTH):0]            occupancy,
  output logic [15:0]                       overflow_cnt,
  output logic [$clog2(DEPTH):0]            high_water
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH) + 1;
  localparam logic [OW-1:0] DEPTH_W = OW'(DEPTH);
  localparam logic [OW-1:0] SLACK_W = OW'(READY_SLACK);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("rmt_stage_link: DEPTH must be a power of two >= 2");
    end
    if (READY_SLACK >= DEPTH) begin : g_bad_slack
      $error("rmt_stage_link: READY_SLACK must be below DEPTH");
    end
    if (STAGE_ID < 0 || STAGE_ID > 4) begin : g_bad_stage
      $error("rmt_stage_link: STAGE_ID must be 0..4");
    end
  endgenerate

  logic [PHV_LEN-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [OW-1:0]      occ_nxt;
  logic               full;
  logic               pop;
  logic               push_acc;
  logic               drop;

  // When full, a pop this cycle frees the slot the incoming push lands in
  assign full          = (occupancy == DEPTH_W);
  assign phv_out_valid = (occupancy != '0);
  assign pop           = phv_out_valid && ready_in;
  assign push_acc      = phv_in_valid && (!full || pop);
  assign drop          = phv_in_valid && full && !pop;
  assign occ_nxt       = occupancy + OW'(push_acc) - OW'(pop);
  assign phv_out       = phv_out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge axis_clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= phv_in;
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occupancy    <= '0;
      ready_out    <= 1'b1;
      overflow_cnt <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PW'(1);
      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      occupancy <= occ_nxt;
      ready_out <= (DEPTH_W - occ_nxt) > SLACK_W;
      if (drop && overflow_cnt != 16'hFFFF) begin
        overflow_cnt <= overflow_cnt + 16'd1;
      end
    end
  end

`ifdef STAGE_LINK_STATS_EN
  logic [OW-1:0] high_water_q;

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      high_water_q <= '0;
    end else if (occ_nxt > high_water_q) begin
      high_water_q <= occ_nxt;
    end
  end

  assign high_water = high_water_q;
`else
  assign high_water = '0;
`endif

  // Control beats: payload is captured only on valid, so idle cycles hold the last beat
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      c_m_axis_tvalid <= 1'b0;
      c_m_axis_tlast  <= 1'b0;
      c_m_axis_tdata  <= '0;
      c_m_axis_tuser  <= '0;
      c_m_axis_tkeep  <= '0;
    end else begin
      c_m_axis_tvalid <= c_s_axis_tvalid;
      if (c_s_axis_tvalid) begin
        c_m_axis_tlast <= c_s_axis_tlast;
        c_m_axis_tdata <= c_s_axis_tdata;
        c_m_axis_tuser <= c_s_axis_tuser;
        c_m_axis_tkeep <= c_s_axis_tkeep;
      end
    end
  end

endmodule

// File: tb/tb_rmt_stage_link.sv
// Randomized and directed bench for rmt_stage_link against a queue-based reference model.
module tb_rmt_stage_link;

  localparam int PHV_LEN = 1124;
  localparam int DEPTH   = 4;
  localparam int SLACK   = 2;
  localparam int DW      = 512;
  localparam int UW      = 128;
  localparam int KW      = DW / 8;
  localparam int OW      = $clog2(DEPTH) + 1;

  logic               axis_clk = 1'b0;
  logic               aresetn  = 1'b1;
  logic [PHV_LEN-1:0] phv_in   = '0;
  logic               phv_in_valid = 1'b0;
  logic               ready_out;
  logic [PHV_LEN-1:0] phv_out;
  logic               phv_out_valid;
  logic               ready_in = 1'b0;
  logic [DW-1:0]      c_s_axis_tdata  = '0;
  logic [UW-1:0]      c_s_axis_tuser  = '0;
  logic [KW-1:0]      c_s_axis_tkeep  = '0;
  logic               c_s_axis_tvalid = 1'b0;
  logic               c_s_axis_tlast  = 1'b0;
  logic [DW-1:0]      c_m_axis_tdata;
  logic [UW-1:0]      c_m_axis_tuser;
  logic [KW-1:0]      c_m_axis_tkeep;
  logic               c_m_axis_tvalid;
  logic               c_m_axis_tlast;
  logic [OW-1:0]      occupancy;
  logic [15:0]        overflow_cnt;
  logic [OW-1:0]      high_water;

  rmt_stage_link #(
    .PHV_LEN(PHV_LEN), .DEPTH(DEPTH), .READY_SLACK(SLACK),
    .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .STAGE_ID(0)
  ) dut (
    .axis_clk(axis_clk), .aresetn(aresetn),
    .phv_in(phv_in), .phv_in_valid(phv_in_valid), .ready_out(ready_out),
    .phv_out(phv_out), .phv_out_valid(phv_out_valid), .ready_in(ready_in),
    .c_s_axis_tdata(c_s_axis_tdata), .c_s_axis_tuser(c_s_axis_tuser),
    .c_s_axis_tkeep(c_s_axis_tkeep), .c_s_axis_tvalid(c_s_axis_tvalid),
    .c_s_axis_tlast(c_s_axis_tlast),
    .c_m_axis_tdata(c_m_axis_tdata), .c_m_axis_tuser(c_m_axis_tuser),
    .c_m_axis_tkeep(c_m_axis_tkeep), .c_m_axis_tvalid(c_m_axis_tvalid),
    .c_m_axis_tlast(c_m_axis_tlast),
    .occupancy(occupancy), .overflow_cnt(overflow_cnt), .high_water(high_water)
  );

  always #5 axis_clk = ~axis_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [PHV_LEN-1:0] m_q [$];
  int                 m_ovf;
  int                 m_hw;
  logic               m_rdy;
  logic               m_cv;
  logic               m_cl;
  logic [DW-1:0]      m_cd;
  logic [UW-1:0]      m_cu;
  logic [KW-1:0]      m_ck;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PHV_LEN-1:0] mk_phv(input logic [63:0] lo, input logic [31:0] hi);
    logic [PHV_LEN-1:0] v;
    v = '0;
    v[63:0] = lo;
    v[PHV_LEN-1 -: 32] = hi;
    return v;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_ovf = 0;
    m_hw  = 0;
    m_rdy = 1'b1;
    m_cv  = 1'b0;
    m_cl  = 1'b0;
    m_cd  = '0;
    m_cu  = '0;
    m_ck  = '0;
  endtask

  task automatic compare_all();
    int exp_hw;
`ifdef STAGE_LINK_STATS_EN
    exp_hw = m_hw;
`else
    exp_hw = 0;
`endif
    check_val("occupancy", 128'(occupancy), 128'(m_q.size()));
    check_val("phv_out_valid", 128'(phv_out_valid), 128'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check_val("phv_out_lo", phv_out[127:0], m_q[0][127:0]);
      check_val("phv_out_hi", 128'(phv_out[PHV_LEN-1 -: 32]), 128'(m_q[0][PHV_LEN-1 -: 32]));
    end
    check_val("ready_out", 128'(ready_out), 128'(m_rdy));
    check_val("overflow_cnt", 128'(overflow_cnt), 128'(m_ovf));
    check_val("high_water", 128'(high_water), 128'(exp_hw));
    check_val("c_tvalid", 128'(c_m_axis_tvalid), 128'(m_cv));
    check_val("c_tdata_lo", c_m_axis_tdata[127:0], m_cd[127:0]);
    check_val("c_tdata_hi", 128'(c_m_axis_tdata[DW-1 -: 32]), 128'(m_cd[DW-1 -: 32]));
    check_val("c_tuser", c_m_axis_tuser, m_cu);
    check_val("c_tkeep", 128'(c_m_axis_tkeep), 128'(m_ck));
    if (m_cv) check_val("c_tlast", 128'(c_m_axis_tlast), 128'(m_cl));
  endtask

  // Apply current inputs across one clock edge, advance the model, then compare
  task automatic cycle();
    bit pop;
    bit push;
    pop  = (m_q.size() != 0) && ready_in;
    push = phv_in_valid && ((m_q.size() < DEPTH) || pop);
    if (phv_in_valid && !push && m_ovf < 16'hFFFF) m_ovf++;
    if (pop)  m_q.delete(0);
    if (push) m_q.push_back(phv_in);
    m_rdy = (DEPTH - m_q.size()) > SLACK;
    if (m_q.size() > m_hw) m_hw = m_q.size();
    m_cv = c_s_axis_tvalid;
    if (c_s_axis_tvalid) begin
      m_cd = c_s_axis_tdata;
      m_cu = c_s_axis_tuser;
      m_ck = c_s_axis_tkeep;
      m_cl = c_s_axis_tlast;
    end
    @(posedge axis_clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset(input string tag);
    phv_in_valid    = 1'b0;
    ready_in        = 1'b0;
    c_s_axis_tvalid = 1'b0;
    c_s_axis_tlast  = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    model_clear();
    check_val({tag, "_occ"}, 128'(occupancy), 128'd0);
    check_val({tag, "_vld"}, 128'(phv_out_valid), 128'd0);
    check_val({tag, "_phv"}, phv_out[127:0], 128'd0);
    check_val({tag, "_rdy"}, 128'(ready_out), 128'd1);
    check_val({tag, "_ovf"}, 128'(overflow_cnt), 128'd0);
    check_val({tag, "_hw"}, 128'(high_water), 128'd0);
    check_val({tag, "_ctv"}, 128'(c_m_axis_tvalid), 128'd0);
    check_val({tag, "_ctl"}, 128'(c_m_axis_tlast), 128'd0);
    check_val({tag, "_ctd"}, c_m_axis_tdata[127:0], 128'd0);
    @(posedge axis_clk);
    @(posedge axis_clk);
    #3 aresetn = 1'b1;
  endtask

  task automatic push_phv(input logic [63:0] v, input logic rdy);
    phv_in       = mk_phv(v, 32'h0);
    phv_in_valid = 1'b1;
    ready_in     = rdy;
    cycle();
    phv_in_valid = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    phv_in_valid = 1'b0;
    ready_in     = rdy;
    cycle();
  endtask

  initial begin
    model_clear();
    #1;
    do_reset("rst0");

    // Single push appears one cycle later
    push_phv(64'hA5, 1'b0);
    check_val("t1_head", phv_out[127:0], 128'hA5);
    check_val("t1_vld", 128'(phv_out_valid), 128'd1);
    idle(1'b1);
    check_val("t1_empty", 128'(occupancy), 128'd0);

    // Back-pressure fill: ready_out falls after 2nd push, control beats flow meanwhile
    push_phv(64'd1, 1'b0);
    check_val("bp_rdy1", 128'(ready_out), 128'd1);
    c_s_axis_tdata = 512'h1; c_s_axis_tuser = 128'h11; c_s_axis_tkeep = '1;
    c_s_axis_tvalid = 1'b1; c_s_axis_tlast = 1'b0;
    push_phv(64'd2, 1'b0);
    check_val("bp_rdy2", 128'(ready_out), 128'd0);
    check_val("ctl_beat1", c_m_axis_tdata[127:0], 128'h1);
    c_s_axis_tdata = 512'h2; c_s_axis_tuser = 128'h22; c_s_axis_tlast = 1'b1;
    push_phv(64'd3, 1'b0);
    check_val("ctl_beat2", c_m_axis_tdata[127:0], 128'h2);
    check_val("ctl_last2", 128'(c_m_axis_tlast), 128'd1);
    c_s_axis_tvalid = 1'b0; c_s_axis_tlast = 1'b0;
    push_phv(64'd4, 1'b0);
    check_val("ctl_idle", 128'(c_m_axis_tvalid), 128'd0);
    check_val("full_occ", 128'(occupancy), 128'd4);
    check_val("full_ovf0", 128'(overflow_cnt), 128'd0);

    // Overflow drop, then in-order drain
    push_phv(64'd5, 1'b0);
    check_val("drop_ovf", 128'(overflow_cnt), 128'd1);
    check_val("drop_occ", 128'(occupancy), 128'd4);
    for (int i = 1; i <= 4; i++) begin
      check_val("drain_order", phv_out[127:0], 128'(i));
      idle(1'b1);
    end
    check_val("drain_empty", 128'(phv_out_valid), 128'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) push_phv(64'h11 + 64'(i), 1'b0);
    push_phv(64'h77, 1'b1);
    check_val("pp_occ", 128'(occupancy), 128'd4);
    check_val("pp_ovf", 128'(overflow_cnt), 128'd1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    check_val("pp_last", phv_out[127:0], 128'h77);
    idle(1'b1);

    // Watermark then mid-stream reset
    do_reset("rst1");
    for (int i = 0; i < 3; i++) push_phv(64'h30 + 64'(i), 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    push_phv(64'h40, 1'b0);
    push_phv(64'h41, 1'b0);
    do_reset("rst2");
    idle(1'b1);

    // Randomized phases: heavy fill, fast drain, mixed
    for (int i = 0; i < 600; i++) begin
      int mode;
      mode = (i / 100) % 3;
      phv_in       = mk_phv({$urandom, $urandom}, $urandom);
      phv_in_valid = $urandom_range(0, 99) < ((mode == 0) ? 80 : 45);
      ready_in     = $urandom_range(0, 99) < ((mode == 0) ? 20 : (mode == 1) ? 90 : 50);
      c_s_axis_tvalid = $urandom_range(0, 1) == 1;
      c_s_axis_tlast  = $urandom_range(0, 3) == 0;
      c_s_axis_tdata  = '0;
      c_s_axis_tdata[63:0] = {$urandom, $urandom};
      c_s_axis_tdata[DW-1 -: 32] = $urandom;
      c_s_axis_tuser  = {$urandom, $urandom, $urandom, $urandom};
      c_s_axis_tkeep  = {$urandom, $urandom};
      cycle();
      if (i == 333) do_reset("rst_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
